// File: rtl/vram_scan_prefetch.sv
// VGA-side scanout fetch engine: credit-controlled VRAM prefetch into a show-ahead FIFO,
// with frame-based addressing, frame-start flush of stale returns and underflow detection.
module vram_scan_prefetch #(
    parameter int unsigned ADDR_W      = 15,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned MAX_OUT     = 4,
    parameter int unsigned LAT         = 1,
    parameter int unsigned FRAME_WORDS = 24576
) (
    input  logic                     vga_clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     frame_start,
    input  logic [ADDR_W-1:0]        base_addr,
    output logic [ADDR_W-1:0]        vram_addr,
    output logic                     vram_req,
    input  logic                     vram_ready,
    input  logic [DATA_W-1:0]        vram_data,
    output logic [DATA_W-1:0]        pix_data,
    output logic                     pix_valid,
    input  logic                     pix_pop,
    output logic                     underflow,
    output logic                     frame_done,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);
    localparam int unsigned CNT_W = $clog2(FRAME_WORDS + 1);
    localparam int unsigned QW    = $clog2(LAT + 2);
    localparam int unsigned CR_W  = ((LVL_W > OUT_W) ? LVL_W : OUT_W) + 1;

    typedef enum logic [1:0] {IDLE, FLUSH, RUN, DONE} state_t;

    state_t             state;
    logic [QW-1:0]      quiet;
    logic [OUT_W-1:0]   outstanding;
    logic [CNT_W-1:0]   req_cnt;
    logic [ADDR_W-1:0]  fetch_addr;
    logic               armed;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;

    logic               credit_ok;
    logic               issue;
    logic               push;
    logic               pop;
    logic [OUT_W-1:0]   out_next;
    logic [LVL_W-1:0]   level_next;
    logic [PTR_W-1:0]   rd_ptr_next;

    // Issue gating: credits count in-flight reads so the FIFO can never overflow.
    always_comb begin
        credit_ok   = (CR_W'(level) + CR_W'(outstanding)) < CR_W'(DEPTH);
        issue       = (state == RUN) && enable
                      && (outstanding < OUT_W'(MAX_OUT))
                      && credit_ok
                      && (req_cnt < CNT_W'(FRAME_WORDS));
        push        = vram_ready && ((state == RUN) || (state == DONE));
        pop         = pix_pop && (level != '0);
        out_next    = outstanding;
        if (issue && !push) begin
            out_next = outstanding + OUT_W'(1);
        end else if (!issue && push) begin
            out_next = outstanding - OUT_W'(1);
        end
        level_next  = level + LVL_W'(push) - LVL_W'(pop);
        rd_ptr_next = rd_ptr + PTR_W'(pop);
    end

    // FIFO storage carries no reset; pointers and level define validity.
    always_ff @(posedge vga_clk) begin
        if (push && !reset && !frame_start) begin
            mem[wr_ptr] <= vram_data;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state       <= FLUSH;
            quiet       <= QW'(LAT + 1);
            outstanding <= '0;
            req_cnt     <= '0;
            fetch_addr  <= '0;
            armed       <= 1'b0;
            vram_req    <= 1'b0;
            vram_addr   <= '0;
            pix_data    <= '0;
            pix_valid   <= 1'b0;
            underflow   <= 1'b0;
            frame_done  <= 1'b0;
            level       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else if (frame_start) begin
            // Pops and returns in this cycle are dropped; FLUSH swallows stale returns.
            state       <= FLUSH;
            quiet       <= QW'(LAT + 1);
            outstanding <= '0;
            req_cnt     <= '0;
            fetch_addr  <= base_addr;
            armed       <= 1'b1;
            vram_req    <= 1'b0;
            pix_valid   <= 1'b0;
            underflow   <= 1'b0;
            frame_done  <= 1'b0;
            level       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            vram_req    <= issue;
            outstanding <= out_next;
            if (issue) begin
                vram_addr  <= fetch_addr;
                fetch_addr <= fetch_addr + ADDR_W'(1);
                req_cnt    <= req_cnt + CNT_W'(1);
            end

            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr    <= rd_ptr_next;
            level     <= level_next;
            pix_valid <= (level_next != '0);
            if (pix_pop && (level == '0)) begin
                underflow <= 1'b1;
            end

            // Head register: bypass the incoming word when the FIFO would otherwise be empty.
            if (push && (level == LVL_W'(pop))) begin
                pix_data <= vram_data;
            end else if (level_next != '0) begin
                pix_data <= mem[rd_ptr_next];
            end

            case (state)
                FLUSH: begin
                    if (quiet == '0) begin
                        state <= armed ? RUN : IDLE;
                        armed <= 1'b0;
                    end else begin
                        quiet <= quiet - QW'(1);
                    end
                end
                RUN: begin
                    if (issue && ((req_cnt + CNT_W'(1)) == CNT_W'(FRAME_WORDS))) begin
                        state <= DONE;
                    end
                end
                default: begin
                end
            endcase

            frame_done <= (state == DONE) && (out_next == '0);
        end
    end

endmodule
